instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Host-side program loader for the 17-bit MCU: it produces the instruction words that the core's decoder consumes.
- Accepts symbolic instruction fields (opcode, DA, AA, BA, immediate) over a valid/ready stream.
- Packs each instruction into the 17-bit format, zeroing the fields the decoder ignores for that opcode.
- Writes the words into instruction memory at consecutive addresses.
- Rejects illegal opcodes and guards against memory overflow.

Parameters:
ADDR_W, 8, instruction-memory address width; depth = 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load session at base_addr (ignored unless IDLE)
base_addr  input  ADDR_W  first write address for the session
s_valid  input  1  instruction fields valid
s_ready  output  1  loader can accept fields
s_last  input  1  marks final instruction of the session
s_opcode  input  5  opcode
s_da  input  3  destination register
s_aa  input  3  source A register
s_ba  input  3  source B register
s_imm  input  9  immediate / jump or branch target
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  17  encoded instruction
busy  output  1  session in progress
done  output  1  one-cycle pulse, session ended cleanly
err  output  1  sticky until next start; session aborted
err_code  output  2  01 illegal opcode, 10 overflow, 00 none
words_written  output  ADDR_W+1  count of words written in the current session

Behaviour:
- Word format: [16:12] opcode, [11:9] DA, [8:6] AA, [5:3] BA, [2:0] zero. Fields not listed below are forced to 0 regardless of input.
- 00000 NOP: entire word 0.
- 00001 ADD, 00100 SUB, 00101 SLT, 01110 XOR, 10100 IN: DA, AA, BA.
- 10101 OUT: AA, BA; DA = 0.
- 00010 ANDI, 00011 ADDI, 01101 ORI: DA, AA, [5:0] = s_imm[5:0].
- 00110 NOT, 00111 LD, 01001 MOV, 01111 LSR, 10001 LSL: DA, AA.
- 01000 ST: AA only.
- 01011 JR: BA only.
- 01010 J, 10010 BZ, 10011 BNZ: [8:0] = s_imm; DA = 0.
- 01100 JAL: DA, [8:0] = s_imm.
- Illegal opcodes: 10000 and 10110..11111.
- FSM states: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE: s_ready = 0, busy = 0. start → ACCEPT; on entry, addr <= base_addr, words_written <= 0, err/err_code cleared.
- ACCEPT: s_ready = 1, busy = 1. On s_valid & s_ready:
  - Legal opcode: encoded word and s_last are registered; → WRITE.
  - Illegal opcode: err = 1, err_code = 01; → ERROR. No write occurs.
- WRITE: s_ready = 0. mem_we = 1 for exactly one cycle, with mem_addr = current addr and mem_wdata = registered word. words_written increments. Next state:
  - captured s_last = 1 → DONE.
  - else addr == 2**ADDR_W-1 → ERROR with err_code = 10; addr does not wrap.
  - else addr + 1 → ACCEPT.
- DONE: done = 1 for one cycle → IDLE.
- ERROR: busy = 0, s_ready = 0; err holds. start → ACCEPT.
- Latency and throughput:
  - Handshake in cycle N gives mem_we in cycle N+1.
  - Max throughput is one instruction per 2 cycles.
  - s_ready is a registered function of state only; it never depends on s_valid.
- mem_addr and mem_wdata hold their last values when mem_we = 0.
- start while busy is ignored. s_valid in IDLE, DONE or ERROR is not accepted.
- Reset values (asynchronous, applied immediately even mid-WRITE): state IDLE, s_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err 0, err_code 00, words_written 0.
- A word in flight at reset is discarded.

Test Plan:
- start with base 0x10; send ADD (DA=3, AA=1, BA=2), s_last = 1 → one mem_we at addr 0x10 with wdata 0x01650 one cycle after the handshake; done pulses; words_written = 1.
- Send ST (DA=5, AA=4, BA=6) → wdata 0x08100 (DA and BA zeroed). Send J (imm=0x1A5, DA=7) → wdata 0x0A1A5.
- Send opcode 10000 → no mem_we; err = 1, err_code = 01, s_ready = 0; a new start clears err.
- ADDR_W=2, base 2, three instructions, no s_last → writes at 2 and 3 only; err_code = 10; third instruction never accepted; words_written = 2.
- Hold s_valid continuously with 4 instructions → s_ready toggles 1/0; 4 writes at consecutive addresses spaced 2 cycles apart; done after the fourth.
- Assert rst_n = 0 during a WRITE cycle → mem_we drops immediately; all outputs 0; no further write after reset release until a new start.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Host-side program loader: packs symbolic instruction fields into 17-bit words and writes them to
// consecutive instruction-memory addresses, rejecting illegal opcodes and memory overflow.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic [4:0]        s_opcode,
  input  logic [2:0]        s_da,
  input  logic [2:0]        s_aa,
  input  logic [2:0]        s_ba,
  input  logic [8:0]        s_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [16:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {StIdle, StAccept, StWrite, StDone, StError} state_e;

  localparam logic [ADDR_W-1:0] AddrMax = '1;
  localparam logic [1:0] ErrIllegal  = 2'b01;
  localparam logic [1:0] ErrOverflow = 2'b10;

  state_e            state_q, state_d;
  logic [16:0]       enc_word;
  logic              enc_legal;
  logic              hs;
  logic              can_start;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [16:0]       wdata_q;
  logic              last_q;
  logic              err_q;
  logic [1:0]        err_code_q;
  logic [ADDR_W:0]   count_q;

  // Field packing; anything the decoder ignores for the opcode is forced to zero.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (s_opcode)
      5'b00000: enc_word = '0;
      5'b00001, 5'b00100, 5'b00101, 5'b01110, 5'b10100:
        enc_word = {s_opcode, s_da, s_aa, s_ba, 3'b000};
      5'b10101:
        enc_word = {s_opcode, 3'b000, s_aa, s_ba, 3'b000};
      5'b00010, 5'b00011, 5'b01101:
        enc_word = {s_opcode, s_da, s_aa, s_imm[5:0]};
      5'b00110, 5'b00111, 5'b01001, 5'b01111, 5'b10001:
        enc_word = {s_opcode, s_da, s_aa, 6'b000000};
      5'b01000:
        enc_word = {s_opcode, 3'b000, s_aa, 6'b000000};
      5'b01011:
        enc_word = {s_opcode, 6'b000000, s_ba, 3'b000};
      5'b01010, 5'b10010, 5'b10011:
        enc_word = {s_opcode, 3'b000, s_imm};
      5'b01100:
        enc_word = {s_opcode, s_da, s_imm};
      default: enc_legal = 1'b0;
    endcase
  end

  assign hs        = s_valid && (state_q == StAccept);
  assign can_start = start && ((state_q == StIdle) || (state_q == StError));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StAccept;
      StAccept: if (s_valid) state_d = enc_legal ? StWrite : StError;
      StWrite: begin
        if (last_q) begin
          state_d = StDone;
        end else if (addr_q == AddrMax) begin
          state_d = StError;
        end else begin
          state_d = StAccept;
        end
      end
      StDone:   state_d = StIdle;
      StError:  if (start) state_d = StAccept;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    s_ready = (state_q == StAccept);
    mem_we  = (state_q == StWrite);
    busy    = (state_q == StAccept) || (state_q == StWrite);
    done    = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      count_q    <= '0;
    end else begin
      if (can_start) begin
        addr_q     <= base_addr;
        count_q    <= '0;
        err_q      <= 1'b0;
        err_code_q <= 2'b00;
      end
      if (hs) begin
        if (enc_legal) begin
          waddr_q <= addr_q;
          wdata_q <= enc_word;
          last_q  <= s_last;
        end else begin
          err_q      <= 1'b1;
          err_code_q <= ErrIllegal;
        end
      end
      if (state_q == StWrite) begin
        count_q <= count_q + 1'b1;
        if (!last_q) begin
          // The top address is the last usable slot; never wrap back to zero.
          if (addr_q == AddrMax) begin
            err_q      <= 1'b1;
            err_code_q <= ErrOverflow;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
      end
    end
  end

  assign mem_addr      = waddr_q;
  assign mem_wdata     = wdata_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign words_written = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: scoreboarded writes, error paths, overflow on a
// narrow-address instance, back-to-back throughput and reset during a write.
module tb_instr_encoder_loader;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  da;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic [8:0]  imm;
    logic [16:0] w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic        s_valid, s_ready, s_last;
  logic [4:0]  s_opcode;
  logic [2:0]  s_da, s_aa, s_ba;
  logic [8:0]  s_imm;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [16:0] mem_wdata;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [8:0]  words_written;

  logic        b_start;
  logic [1:0]  b_base;
  logic        b_s_valid, b_s_ready;
  logic        b_mem_we;
  logic [1:0]  b_mem_addr;
  logic [16:0] b_mem_wdata;
  logic        b_busy, b_done, b_err;
  logic [1:0]  b_err_code;
  logic [2:0]  b_words;

  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;
  logic [24:0] q[$];
  logic [24:0] q2[$];
  logic [7:0]  exp_addr;
  vec_t        tbl[10];

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_opcode(s_opcode),
    .s_da(s_da), .s_aa(s_aa), .s_ba(s_ba), .s_imm(s_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .words_written(words_written)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .base_addr(b_base),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_last(1'b0), .s_opcode(5'b00001),
    .s_da(3'd3), .s_aa(3'd1), .s_ba(3'd2), .s_imm(9'h000),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_err_code), .words_written(b_words)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: every write strobe must match the oldest expected {addr, word}.
  always @(posedge clk) begin
    logic [24:0] e;
    #1;
    if (mem_we) begin
      check("write_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[24:17]));
        check("wr_data", 32'(mem_wdata), 32'(e[16:0]));
      end
    end
  end

  always @(posedge clk) begin
    logic [24:0] e;
    #1;
    if (b_mem_we) begin
      check("b_write_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("b_wr_addr", 32'(b_mem_addr), 32'(e[24:17]));
        check("b_wr_data", 32'(b_mem_wdata), 32'(e[16:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    exp_addr = b;
    @(negedge clk);
    start = 1'b0;
    check("start_err", 32'(err), 32'd0);
    check("start_code", 32'(err_code), 32'd0);
    check("start_words", 32'(words_written), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(s_ready), 32'd1);
  endtask

  // Drives one instruction, waits (bounded) for the handshake, then checks the
  // write strobe appears exactly one cycle later when one is expected.
  task automatic send_fields(input logic [4:0] op, input logic [2:0] da, input logic [2:0] aa,
                             input logic [2:0] ba, input logic [8:0] imm, input logic [16:0] w,
                             input bit last, input bit exp_write);
    int n;
    @(negedge clk);
    s_opcode = op; s_da = da; s_aa = aa; s_ba = ba; s_imm = imm;
    s_last = last;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hs_ready", 32'(s_ready), 32'd1);
    if (exp_write) begin
      q.push_back({exp_addr, w});
      exp_addr++;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("we_latency", 32'(mem_we), 32'(exp_write));
  endtask

  task automatic send_one(input int i, input bit last);
    send_fields(tbl[i].op, tbl[i].da, tbl[i].aa, tbl[i].ba, tbl[i].imm, tbl[i].w, last, 1'b1);
  endtask

  task automatic finish_session(input int words);
    @(posedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd1);
    check("done_words", 32'(words_written), 32'(words));
    check("done_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    check("done_single", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int idx;
    int cyc;
    tbl[0] = '{5'b01000, 3'd5, 3'd4, 3'd6, 9'h000, 17'h08100};  // ST
    tbl[1] = '{5'b01010, 3'd7, 3'd3, 3'd2, 9'h1A5, 17'h0A1A5};  // J
    tbl[2] = '{5'b00010, 3'd2, 3'd5, 3'd7, 9'h1FF, 17'h0257F};  // ANDI
    tbl[3] = '{5'b10101, 3'd7, 3'd3, 3'd4, 9'h000, 17'h150E0};  // OUT
    tbl[4] = '{5'b00110, 3'd1, 3'd6, 3'd5, 9'h1FF, 17'h06380};  // NOT
    tbl[5] = '{5'b01011, 3'd7, 3'd7, 3'd3, 9'h1FF, 17'h0B018};  // JR
    tbl[6] = '{5'b01100, 3'd4, 3'd7, 3'd7, 9'h0F3, 17'h0C8F3};  // JAL
    tbl[7] = '{5'b00000, 3'd7, 3'd7, 3'd7, 9'h1FF, 17'h00000};  // NOP
    tbl[8] = '{5'b10010, 3'd5, 3'd1, 3'd1, 9'h155, 17'h12155};  // BZ
    tbl[9] = '{5'b10100, 3'd6, 3'd2, 3'd1, 9'h000, 17'h14C88};  // IN

    rst_n = 1'b0; start = 1'b0; base_addr = '0; s_valid = 1'b0; s_last = 1'b0;
    s_opcode = '0; s_da = '0; s_aa = '0; s_ba = '0; s_imm = '0;
    b_start = 1'b0; b_base = '0; b_s_valid = 1'b0; exp_addr = '0;
    #2;
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_flags", 32'({busy, done, err, err_code}), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ADD with last.
    do_start(8'h10);
    send_fields(5'b00001, 3'd3, 3'd1, 3'd2, 9'h000, 17'h01650, 1'b1, 1'b1);
    finish_session(1);

    // Field masking across opcode classes; a start mid-session is ignored.
    do_start(8'h20);
    for (int i = 0; i < 3; i++) send_one(i, 1'b0);
    @(negedge clk);
    start = 1'b1;
    base_addr = 8'h99;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_ignored_busy", 32'(busy), 32'd1);
    for (int i = 3; i < 10; i++) send_one(i, i == 9);
    finish_session(10);

    // Illegal opcodes.
    do_start(8'h40);
    send_fields(5'b10000, 3'd1, 3'd1, 3'd1, 9'h0, 17'h0, 1'b0, 1'b0);
    check("ill_err", 32'(err), 32'd1);
    check("ill_code", 32'(err_code), 32'd1);
    check("ill_ready", 32'(s_ready), 32'd0);
    check("ill_busy", 32'(busy), 32'd0);
    s_opcode = 5'b00001;
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("err_hold", 32'(err), 32'd1);
    check("err_no_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    do_start(8'h40);
    send_fields(5'b10110, 3'd1, 3'd1, 3'd1, 9'h0, 17'h0, 1'b0, 1'b0);
    check("ill2_code", 32'(err_code), 32'd1);
    do_start(8'h40);
    send_fields(5'b11111, 3'd1, 3'd1, 3'd1, 9'h0, 17'h0, 1'b0, 1'b0);
    check("ill3_err", 32'(err), 32'd1);
    check("ill3_words", 32'(words_written), 32'd0);

    // Overflow on the 2-bit address instance: base 2, valid held, never last.
    @(negedge clk);
    b_start = 1'b1;
    b_base = 2'd2;
    @(negedge clk);
    b_start = 1'b0;
    q2.push_back({8'd2, 17'h01650});
    q2.push_back({8'd3, 17'h01650});
    b_s_valid = 1'b1;
    n = 0;
    repeat (12) begin
      if (b_s_ready) n++;
      @(negedge clk);
    end
    b_s_valid = 1'b0;
    check("ovf_accepts", 32'(n), 32'd2);
    check("ovf_err", 32'(b_err), 32'd1);
    check("ovf_code", 32'(b_err_code), 32'd2);
    check("ovf_words", 32'(b_words), 32'd2);
    check("ovf_ready", 32'(b_s_ready), 32'd0);

    // Back-to-back with s_valid held high: ready alternates, one write per two cycles.
    do_start(8'h80);
    s_valid = 1'b1;
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 40) begin
      s_opcode = tbl[4 + idx].op; s_da = tbl[4 + idx].da; s_aa = tbl[4 + idx].aa;
      s_ba = tbl[4 + idx].ba; s_imm = tbl[4 + idx].imm;
      s_last = (idx == 3);
      check("cont_ready", 32'(s_ready), 32'(cyc % 2 == 0));
      check("cont_we", 32'(mem_we), 32'(cyc % 2 == 1));
      if (s_ready) begin
        q.push_back({exp_addr, tbl[4 + idx].w});
        exp_addr++;
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("cont_count", 32'(idx), 32'd4);
    check("cont_last_we", 32'(mem_we), 32'd1);
    finish_session(4);

    // Reset asserted during a write cycle.
    do_start(8'hF0);
    send_one(3, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstw_we", 32'(mem_we), 32'd0);
    check("rstw_addr", 32'(mem_addr), 32'd0);
    check("rstw_wdata", 32'(mem_wdata), 32'd0);
    check("rstw_flags", 32'({s_ready, busy, done, err, err_code}), 32'd0);
    check("rstw_words", 32'(words_written), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_ready", 32'(s_ready), 32'd0);
      check("post_rst_we", 32'(mem_we), 32'd0);
    end
    s_valid = 1'b0;

    check("sb_empty", 32'(q.size()), 32'd0);
    check("sb2_empty", 32'(q2.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
